// File: rtl/cache_request_driver_if.sv
// Word-level request bundle between the CPU-side command source, the request driver and the cache system.
// The master modport is the driver's view; the slave modport is the environment's view.
interface cache_request_driver_if #(
  parameter int unsigned ADDR_LENGTH = 15,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned LAT_WIDTH   = 16
);
  // Command side
  logic                   cmdValid;
  logic                   cmdReady;
  logic                   cmdWrite;
  logic [ADDR_LENGTH-1:0] cmdAddr;
  logic [DATA_WIDTH-1:0]  cmdData;

  // Cache-system side
  logic [ADDR_LENGTH-1:0] addrOut;
  logic                   enableOut;
  logic                   writeOut;
  logic [DATA_WIDTH-1:0]  dataOut;
  logic                   requestComplete;
  logic [DATA_WIDTH-1:0]  dataIn;

  // Response side
  logic                   respValid;
  logic                   respWrite;
  logic                   respTimeout;
  logic [DATA_WIDTH-1:0]  respData;
  logic [LAT_WIDTH-1:0]   respLatency;

  modport master (
    input  cmdValid, cmdWrite, cmdAddr, cmdData, requestComplete, dataIn,
    output cmdReady, addrOut, enableOut, writeOut, dataOut,
           respValid, respWrite, respTimeout, respData, respLatency
  );

  modport slave (
    output cmdValid, cmdWrite, cmdAddr, cmdData, requestComplete, dataIn,
    input  cmdReady, addrOut, enableOut, writeOut, dataOut,
           respValid, respWrite, respTimeout, respData, respLatency
  );
endinterface

// File: rtl/cache_request_driver.sv
// Buffers read/write commands in a FIFO and issues them one at a time to the cache system,
// reporting per-request latency, timeouts and running request/hit counts.
module cache_request_driver #(
  parameter int unsigned ADDR_LENGTH   = 15,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned LAT_WIDTH     = 16,
  parameter int unsigned HIT_THRESHOLD = 10,
  parameter int unsigned TIMEOUT       = 4095
) (
  input  logic                          clock,
  input  logic                          reset,
  cache_request_driver_if.master        bus,
  output logic                          busy,
  output logic [LAT_WIDTH-1:0]          reqCount,
  output logic [LAT_WIDTH-1:0]          hitCount
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic                   write;
    logic [ADDR_LENGTH-1:0] addr;
    logic [DATA_WIDTH-1:0]  data;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

  cmd_t             fifoMem [FIFO_DEPTH];
  cmd_t             head;
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] fifoCnt;
  logic             fifoFull;
  logic             fifoEmpty;
  logic             pushEn;
  logic             popEn;

  state_t                 state;
  logic [LAT_WIDTH-1:0]   latCnt;
  logic [ADDR_LENGTH-1:0] addrReg;
  logic                   writeReg;
  logic [DATA_WIDTH-1:0]  dataReg;
  logic                   enableReg;
  logic                   respValidReg;
  logic                   respWriteReg;
  logic                   respTimeoutReg;
  logic [DATA_WIDTH-1:0]  respDataReg;
  logic [LAT_WIDTH-1:0]   respLatReg;
  logic [LAT_WIDTH-1:0]   reqCntReg;
  logic [LAT_WIDTH-1:0]   hitCntReg;

  assign fifoFull  = (fifoCnt == CNT_W'(FIFO_DEPTH));
  assign fifoEmpty = (fifoCnt == '0);
  assign pushEn    = bus.cmdValid && !fifoFull;
  assign popEn     = (state == IDLE) && !fifoEmpty;
  assign head      = fifoMem[rdPtr];

  // Command storage; contents are don't-care until the count says otherwise.
  always_ff @(posedge clock) begin
    if (pushEn) begin
      fifoMem[wrPtr] <= '{write: bus.cmdWrite, addr: bus.cmdAddr, data: bus.cmdData};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      fifoCnt <= '0;
    end else begin
      if (pushEn) wrPtr <= wrPtr + PTR_W'(1);
      if (popEn)  rdPtr <= rdPtr + PTR_W'(1);
      case ({pushEn, popEn})
        2'b10:   fifoCnt <= fifoCnt + CNT_W'(1);
        2'b01:   fifoCnt <= fifoCnt - CNT_W'(1);
        default: fifoCnt <= fifoCnt;
      endcase
    end
  end

  // Request sequencer: issue from FIFO head, wait for completion or timeout, then force one low cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      latCnt         <= '0;
      addrReg        <= '0;
      writeReg       <= 1'b0;
      dataReg        <= '0;
      enableReg      <= 1'b0;
      respValidReg   <= 1'b0;
      respWriteReg   <= 1'b0;
      respTimeoutReg <= 1'b0;
      respDataReg    <= '0;
      respLatReg     <= '0;
      reqCntReg      <= '0;
      hitCntReg      <= '0;
    end else begin
      respValidReg <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifoEmpty) begin
            addrReg   <= head.addr;
            writeReg  <= head.write;
            dataReg   <= head.write ? head.data : '0;
            enableReg <= 1'b1;
            latCnt    <= LAT_WIDTH'(1);
            state     <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (bus.requestComplete) begin
            enableReg      <= 1'b0;
            respValidReg   <= 1'b1;
            respWriteReg   <= writeReg;
            respTimeoutReg <= 1'b0;
            respLatReg     <= latCnt;
            respDataReg    <= writeReg ? '0 : bus.dataIn;
            reqCntReg      <= reqCntReg + LAT_WIDTH'(1);
            if (latCnt <= LAT_WIDTH'(HIT_THRESHOLD)) hitCntReg <= hitCntReg + LAT_WIDTH'(1);
            state          <= GAP;
          end else if (latCnt == LAT_WIDTH'(TIMEOUT)) begin
            enableReg      <= 1'b0;
            respValidReg   <= 1'b1;
            respWriteReg   <= writeReg;
            respTimeoutReg <= 1'b1;
            respLatReg     <= LAT_WIDTH'(TIMEOUT);
            respDataReg    <= '0;
            reqCntReg      <= reqCntReg + LAT_WIDTH'(1);
            state          <= GAP;
          end else begin
            latCnt <= latCnt + LAT_WIDTH'(1);
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmdReady    = !fifoFull;
  assign bus.addrOut     = addrReg;
  assign bus.enableOut   = enableReg;
  assign bus.writeOut    = writeReg;
  assign bus.dataOut     = dataReg;
  assign bus.respValid   = respValidReg;
  assign bus.respWrite   = respWriteReg;
  assign bus.respTimeout = respTimeoutReg;
  assign bus.respData    = respDataReg;
  assign bus.respLatency = respLatReg;
  assign busy            = (state != IDLE) || !fifoEmpty;
  assign reqCount        = reqCntReg;
  assign hitCount        = hitCntReg;

endmodule

// File: tb/tb_cache_request_driver.sv
// Scoreboard bench for cache_request_driver: directed commands push expected issues and responses,
// a cache responder model completes requests at planned latencies, and a monitor checks each response.
module tb_cache_request_driver;
  localparam int unsigned AW    = 15;
  localparam int unsigned DW    = 32;
  localparam int unsigned LW    = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned HIT   = 10;
  localparam int unsigned TMO   = 4095;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  cache_request_driver_if #(.ADDR_LENGTH(AW), .DATA_WIDTH(DW), .LAT_WIDTH(LW)) bus ();
  logic          busy;
  logic [LW-1:0] reqCount;
  logic [LW-1:0] hitCount;

  cache_request_driver #(
    .ADDR_LENGTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
    .LAT_WIDTH(LW), .HIT_THRESHOLD(HIT), .TIMEOUT(TMO)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .busy(busy), .reqCount(reqCount), .hitCount(hitCount)
  );

  typedef struct { logic write; logic [AW-1:0] addr; logic [DW-1:0] data; } issue_t;
  typedef struct { logic write; logic timeout; logic [DW-1:0] data; logic [LW-1:0] lat;
                   logic [LW-1:0] req; logic [LW-1:0] hit; } resp_t;
  typedef struct { int unsigned lat; logic [DW-1:0] rdata; } plan_t;

  issue_t      issueQ[$];
  resp_t       respQ[$];
  plan_t       planQ[$];
  int unsigned startQ[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned curLat = 0;
  logic [LW-1:0] mReq = '0;
  logic [LW-1:0] mHit = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer one command; called and returns just after a rising edge. lat==0 means never complete.
  task automatic sendCmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int unsigned lat, input logic [DW-1:0] rd, input bit expectResp);
    int unsigned waitCyc;
    resp_t e;
    waitCyc = 0;
    bus.cmdValid = 1'b1;
    bus.cmdWrite = w;
    bus.cmdAddr  = a;
    bus.cmdData  = d;
    @(negedge clock);
    while (!bus.cmdReady && waitCyc < 2000) begin
      waitCyc++;
      @(negedge clock);
    end
    if (!bus.cmdReady) begin
      chk("cmd accept bound", 0, 1);
      bus.cmdValid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    bus.cmdValid = 1'b0;
    issueQ.push_back('{write: w, addr: a, data: d});
    planQ.push_back('{lat: lat, rdata: rd});
    if (expectResp) begin
      e.write   = w;
      e.timeout = (lat == 0);
      e.lat     = (lat == 0) ? LW'(TMO) : LW'(lat);
      e.data    = (w || lat == 0) ? '0 : rd;
      mReq      = mReq + LW'(1);
      if (lat != 0 && lat <= HIT) mHit = mHit + LW'(1);
      e.req     = mReq;
      e.hit     = mHit;
      respQ.push_back(e);
    end
  endtask

  task automatic waitIdle(input int unsigned budget);
    int unsigned n;
    n = 0;
    @(negedge clock);
    while ((busy || respQ.size() != 0) && n < budget) begin
      n++;
      @(negedge clock);
    end
    if (busy || respQ.size() != 0) chk("idle bound", 0, 1);
    @(posedge clock);
    #1;
  endtask

  // Cache-system model: completes each request at its planned latency and checks issued fields.
  initial begin
    bit active;
    bit stableErr;
    int unsigned k;
    plan_t p;
    issue_t cur;
    logic [AW+DW:0] cap;
    active = 0; stableErr = 0; k = 0;
    p = '{lat: 0, rdata: '0};
    cap = '0;
    bus.requestComplete = 1'b0;
    bus.dataIn = '0;
    forever begin
      @(posedge clock);
      #1;
      bus.requestComplete = 1'b0;
      if (bus.enableOut) begin
        if (!active) begin
          active = 1; k = 1; stableErr = 0;
          startQ.push_back(cyc);
          cap = {bus.writeOut, bus.addrOut, bus.dataOut};
          if (issueQ.size() == 0 || planQ.size() == 0) begin
            chk("unexpected issue", 1, 0);
            p = '{lat: 0, rdata: '0};
          end else begin
            cur = issueQ.pop_front();
            p   = planQ.pop_front();
            chk("issue fields", {bus.writeOut, bus.addrOut, bus.dataOut},
                {cur.write, cur.addr, cur.write ? cur.data : 32'h0});
          end
        end else begin
          k++;
          if ({bus.writeOut, bus.addrOut, bus.dataOut} !== cap) stableErr = 1;
        end
        if (p.lat != 0 && k == p.lat) begin
          bus.requestComplete = 1'b1;
          bus.dataIn = p.rdata;
        end
        curLat = k;
      end else begin
        if (active) chk("request fields held", 128'(stableErr), 0);
        active = 0;
        curLat = 0;
      end
    end
  end

  // Response monitor: every strobe must match the oldest expectation.
  initial begin
    resp_t e;
    forever begin
      @(negedge clock);
      if (reset && bus.respValid) begin
        if (respQ.size() == 0) chk("unexpected response", 1, 0);
        else begin
          e = respQ.pop_front();
          chk("response", {bus.respWrite, bus.respTimeout, bus.respData, bus.respLatency, reqCount, hitCount},
              {e.write, e.timeout, e.data, e.lat, e.req, e.hit});
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned idxA;
    int unsigned n;
    int unsigned nStarts;
    bus.cmdValid = 1'b0;
    bus.cmdWrite = 1'b0;
    bus.cmdAddr  = '0;
    bus.cmdData  = '0;

    // Reset state
    repeat (3) @(negedge clock);
    chk("reset enableOut", bus.enableOut, 0);
    chk("reset respValid", bus.respValid, 0);
    chk("reset reqCount", reqCount, 0);
    chk("reset hitCount", hitCount, 0);
    chk("reset cmdReady", bus.cmdReady, 1);
    chk("reset busy", busy, 0);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Read, latency 3
    sendCmd(1'b0, 15'h0040, 32'h0, 3, 32'hDEADBEEF, 1);
    waitIdle(100);

    // Write, latency 1000
    sendCmd(1'b1, 15'h1234, 32'hA5A5A5A5, 1000, 32'h11112222, 1);
    waitIdle(2000);

    // FIFO full behind a stalled request
    idxA = startQ.size();
    sendCmd(1'b0, 15'h0100, 32'h0, 40, 32'hCAFE0000, 1);
    for (int i = 0; i < 8; i++)
      sendCmd(1'(i % 2), 15'h0200 + 15'(i), 32'h1000 + 32'(i), 1, 32'hB0000000 + 32'(i), 1);
    @(negedge clock);
    chk("full cmdReady", bus.cmdReady, 0);
    chk("full busy", busy, 1);
    @(posedge clock);
    #1;
    sendCmd(1'b1, 15'h0208, 32'h1008, 1, 32'h0, 1);
    chk("ninth accepted after pop", startQ.size(), idxA + 2);
    waitIdle(500);
    for (int i = 1; i < 9; i++)
      chk("issue spacing", startQ[idxA + i + 1] - startQ[idxA + i], 3);

    // Timeout, then the next command still issues
    sendCmd(1'b0, 15'h7FFF, 32'h0, 0, 32'h0, 1);
    sendCmd(1'b1, 15'h0005, 32'h00000055, 2, 32'h0, 1);
    waitIdle(6000);

    // Reset during an active request with another queued
    sendCmd(1'b0, 15'h0333, 32'h0, 0, 32'h0, 0);
    sendCmd(1'b1, 15'h0444, 32'h77, 1, 32'h0, 0);
    n = 0;
    while (curLat != 50 && n < 200) begin
      @(posedge clock);
      #2;
      n++;
    end
    chk("reached latency 50", curLat, 50);
    reset = 1'b0;
    #1;
    chk("mid-reset enableOut", bus.enableOut, 0);
    chk("mid-reset respValid", bus.respValid, 0);
    issueQ.delete();
    planQ.delete();
    respQ.delete();
    mReq = '0;
    mHit = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    nStarts = startQ.size();
    repeat (5) @(negedge clock);
    chk("post-reset busy", busy, 0);
    chk("post-reset cmdReady", bus.cmdReady, 1);
    chk("post-reset reqCount", reqCount, 0);
    chk("post-reset enableOut", bus.enableOut, 0);
    chk("post-reset no issue", startQ.size(), nStarts);
    @(posedge clock);
    #1;

    // Normal operation after reset
    sendCmd(1'b0, 15'h0010, 32'h0, 2, 32'h12345678, 1);
    waitIdle(100);

    chk("responses drained", respQ.size(), 0);
    chk("issues drained", issueQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
